// File: rtl/config_frame_writer_pkg.sv
// Shared types and header layout for the configuration frame writer.
// The state enum and field positions are also used by the readback logic.
package config_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2,
    STROBE = 2'd3
  } writerStateT;

  localparam logic [31:0] defaultSyncWord = 32'hFAB0_FAB1;
  localparam int endOfConfigBit = 31;
  localparam int columnLsb = 16;
  localparam int columnWidth = 8;
  localparam int frameLsb = 0;
  localparam int frameWidth = 5;

  function automatic logic [columnWidth-1:0] headerColumn(input logic [31:0] word);
    return word[columnLsb +: columnWidth];
  endfunction

  function automatic logic [frameWidth-1:0] headerFrame(input logic [31:0] word);
    return word[frameLsb +: frameWidth];
  endfunction

endpackage

// File: rtl/config_frame_writer_if.sv
// Bitstream word stream: 32-bit data with valid/ready handshake.
interface config_frame_writer_if;

  logic [31:0] WordData;
  logic        WordValid;
  logic        WordReady;

  modport master (output WordData, output WordValid, input WordReady);
  modport slave  (input WordData, input WordValid, output WordReady);

endinterface

// File: rtl/config_frame_writer_frame_strobe_decoder.sv
// Column/frame to one-hot strobe decoder; inRange is low for addresses
// outside the fabric and then no strobe bit is produced.
module frame_strobe_decoder
  import config_pkg::*;
#(
  parameter int MaxFramesPerCol = 32,
  parameter int NumColumns      = 4
) (
  input  logic [columnWidth-1:0]                column,
  input  logic [frameWidth-1:0]                 frame,
  output logic [MaxFramesPerCol*NumColumns-1:0] strobe,
  output logic                                  inRange
);

  assign inRange = (int'(column) < NumColumns) && (int'(frame) < MaxFramesPerCol);

  always_comb begin
    strobe = '0;
    for (int c = 0; c < NumColumns; c++) begin
      for (int f = 0; f < MaxFramesPerCol; f++) begin
        if (inRange && int'(column) == c && int'(frame) == f) begin
          strobe[c*MaxFramesPerCol + f] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/config_frame_writer.sv
// Configuration frame writer: waits for the sync word, then loops on
// header + NumRows data words, pulsing one FrameStrobe bit per frame.
module config_frame_writer
  import config_pkg::*;
#(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 32,
  parameter int          NumRows         = 4,
  parameter int          NumColumns      = 4,
  parameter logic [31:0] SyncWord        = defaultSyncWord
) (
  input  logic                                  CLK,
  input  logic                                  reset,
  config_frame_writer_if.slave                  wordBus,
  output logic [FrameBitsPerRow*NumRows-1:0]    FrameData,
  output logic [MaxFramesPerCol*NumColumns-1:0] FrameStrobe,
  output logic                                  Active,
  output logic [15:0]                           FramesWritten,
  output logic                                  Error
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;

  writerStateT                          state;
  logic [RowW-1:0]                      rowCount;
  logic [columnWidth-1:0]               column;
  logic [frameWidth-1:0]                frame;
  logic [MaxFramesPerCol*NumColumns-1:0] decodedStrobe;
  logic                                 addrInRange;
  logic                                 accept;

  assign wordBus.WordReady = !reset && (state != STROBE);
  assign accept = wordBus.WordValid && wordBus.WordReady;

  frame_strobe_decoder #(
    .MaxFramesPerCol(MaxFramesPerCol),
    .NumColumns     (NumColumns)
  ) strobeDecoder (
    .column (column),
    .frame  (frame),
    .strobe (decodedStrobe),
    .inRange(addrInRange)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      state         <= IDLE;
      rowCount      <= '0;
      column        <= '0;
      frame         <= '0;
      FrameData     <= '0;
      FrameStrobe   <= '0;
      Active        <= 1'b0;
      FramesWritten <= '0;
      Error         <= 1'b0;
    end else begin
      FrameStrobe <= '0;
      case (state)
        IDLE: begin
          if (accept && wordBus.WordData == SyncWord) begin
            state  <= HEADER;
            Active <= 1'b1;
          end
        end
        HEADER: begin
          if (accept) begin
            if (wordBus.WordData[endOfConfigBit]) begin
              state  <= IDLE;
              Active <= 1'b0;
            end else begin
              column   <= headerColumn(wordBus.WordData);
              frame    <= headerFrame(wordBus.WordData);
              rowCount <= '0;
              state    <= DATA;
            end
          end
        end
        DATA: begin
          if (accept) begin
            for (int r = 0; r < NumRows; r++) begin
              if (rowCount == RowW'(r)) begin
                FrameData[r*FrameBitsPerRow +: FrameBitsPerRow] <= wordBus.WordData[FrameBitsPerRow-1:0];
              end
            end
            // Strobe is launched on the last data handshake so it lands in the STROBE cycle.
            if (rowCount == RowW'(NumRows-1)) begin
              state <= STROBE;
              if (addrInRange) begin
                FrameStrobe   <= decodedStrobe;
                FramesWritten <= FramesWritten + 16'd1;
              end else begin
                Error <= 1'b1;
              end
            end else begin
              rowCount <= rowCount + 1'b1;
            end
          end
        end
        STROBE: state <= HEADER;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_config_frame_writer.sv
// Directed bench for config_frame_writer: framing, back-pressure,
// bad addresses, end-of-config and reset mid-frame.
module tb_config_frame_writer;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic         CLK;
  logic         reset;
  logic [127:0] FrameData;
  logic [127:0] FrameStrobe;
  logic         Active;
  logic [15:0]  FramesWritten;
  logic         Error;

  int checks = 0;
  int failures = 0;
  int strobeCount = 0;

  config_frame_writer_if wordBus();

  config_frame_writer dut (
    .CLK          (CLK),
    .reset        (reset),
    .wordBus      (wordBus),
    .FrameData    (FrameData),
    .FrameStrobe  (FrameStrobe),
    .Active       (Active),
    .FramesWritten(FramesWritten),
    .Error        (Error)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    #1;
    if (|FrameStrobe) strobeCount++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the handshake.
  task automatic putWord(input logic [31:0] w);
    int waited = 0;
    wordBus.WordData  = w;
    wordBus.WordValid = 1'b1;
    while (!wordBus.WordReady && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (waited >= 20) chk("handshake_timeout", 128'd0, 128'd1);
    @(negedge CLK);
  endtask

  task automatic putWordGap(input logic [31:0] w);
    wordBus.WordValid = 1'b0;
    @(negedge CLK);
    putWord(w);
  endtask

  task automatic dropValid();
    wordBus.WordValid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    wordBus.WordData  = '0;
    wordBus.WordValid = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_ready", 128'(wordBus.WordReady), 128'd0);
    chk("rst_data", FrameData, 128'd0);
    chk("rst_strobe", FrameStrobe, 128'd0);
    chk("rst_active", 128'(Active), 128'd0);
    chk("rst_count", 128'(FramesWritten), 128'd0);
    chk("rst_error", 128'(Error), 128'd0);

    reset = 1'b0;
    @(negedge CLK);
    chk("idle_ready", 128'(wordBus.WordReady), 128'd1);

    // Pre-sync garbage
    putWord(32'h1234_5678);
    chk("garbage1_active", 128'(Active), 128'd0);
    putWord(32'hFAB0_FAB0);
    chk("garbage2_active", 128'(Active), 128'd0);
    putWord(SYNC);
    chk("sync_active", 128'(Active), 128'd1);
    chk("presync_strobes", 128'(strobeCount), 128'd0);
    chk("presync_data", FrameData, 128'd0);

    // Nominal frame, continuous valid
    putWord(32'h0001_0003);
    putWord(32'h1111_1111);
    putWord(32'h2222_2222);
    putWord(32'h3333_3333);
    chk("nom_no_early_strobe", FrameStrobe, 128'd0);
    putWord(32'h4444_4444);
    dropValid();
    chk("nom_strobe", FrameStrobe, 128'd1 << 35);
    chk("nom_strobe_ready", 128'(wordBus.WordReady), 128'd0);
    chk("nom_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    chk("nom_count", 128'(FramesWritten), 128'd1);
    chk("nom_error", 128'(Error), 128'd0);
    @(negedge CLK);
    chk("nom_strobe_off", FrameStrobe, 128'd0);
    chk("nom_header_ready", 128'(wordBus.WordReady), 128'd1);
    chk("nom_strobe_count", 128'(strobeCount), 128'd1);

    // Same frame with valid toggled every other cycle
    putWordGap(32'h0001_0003);
    putWordGap(32'h1111_1111);
    putWordGap(32'h2222_2222);
    putWordGap(32'h3333_3333);
    chk("gap_no_early_strobe", FrameStrobe, 128'd0);
    putWordGap(32'h4444_4444);
    dropValid();
    chk("gap_strobe", FrameStrobe, 128'd1 << 35);
    chk("gap_strobe_ready", 128'(wordBus.WordReady), 128'd0);
    chk("gap_data", FrameData, 128'h44444444_33333333_22222222_11111111);
    chk("gap_count", 128'(FramesWritten), 128'd2);
    @(negedge CLK);
    chk("gap_strobe_off", FrameStrobe, 128'd0);

    // Bad column address, then a good frame at column 0 frame 0
    putWord(32'h0007_0000);
    putWord(32'h0A0A_0A0A);
    putWord(32'h0B0B_0B0B);
    putWord(32'h0C0C_0C0C);
    putWord(32'h0D0D_0D0D);
    dropValid();
    chk("bad_strobe", FrameStrobe, 128'd0);
    chk("bad_error", 128'(Error), 128'd1);
    chk("bad_count", 128'(FramesWritten), 128'd2);
    chk("bad_data", FrameData, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A);
    @(negedge CLK);
    putWord(32'h0000_0000);
    putWord(32'h0000_0001);
    putWord(32'h0000_0002);
    putWord(32'h0000_0003);
    putWord(32'h0000_0004);
    chk("ok_strobe", FrameStrobe, 128'd1);
    chk("ok_error_sticky", 128'(Error), 128'd1);
    chk("ok_count", 128'(FramesWritten), 128'd3);
    chk("ok_data", FrameData, 128'h00000004_00000003_00000002_00000001);

    // End of config, then a stray word in IDLE
    putWord(32'h8000_0000);
    chk("eoc_active", 128'(Active), 128'd0);
    putWord(32'hDEAD_BEEF);
    dropValid();
    chk("eoc_data_held", FrameData, 128'h00000004_00000003_00000002_00000001);
    chk("eoc_still_idle", 128'(Active), 128'd0);
    chk("eoc_strobe_count", 128'(strobeCount), 128'd3);

    // Reset in the middle of DATA
    putWord(SYNC);
    putWord(32'h0003_0005);
    putWord(32'h5555_5555);
    putWord(32'h6666_6666);
    dropValid();
    reset = 1'b1;
    @(negedge CLK);
    chk("mid_rst_data", FrameData, 128'd0);
    chk("mid_rst_strobe", FrameStrobe, 128'd0);
    chk("mid_rst_active", 128'(Active), 128'd0);
    chk("mid_rst_count", 128'(FramesWritten), 128'd0);
    chk("mid_rst_error", 128'(Error), 128'd0);
    chk("mid_rst_ready", 128'(wordBus.WordReady), 128'd0);
    reset = 1'b0;
    @(negedge CLK);
    putWord(32'h7777_7777);
    putWord(32'h8888_8888);
    dropValid();
    repeat (3) @(negedge CLK);
    chk("post_rst_strobes", 128'(strobeCount), 128'd3);
    chk("post_rst_data", FrameData, 128'd0);
    chk("post_rst_active", 128'(Active), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
